// File: rtl/parity_frame_tx_if.sv
// Handshake and serial-line bundle for the parity framing transmitter.
// The upstream producer uses the master view; the transmitter uses the slave view.
interface parity_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              odd_sel;
    logic              in_valid;
    logic              in_ready;
    logic              tx_out;
    logic              busy;
    logic              frame_done;

    modport master (
        output data_in,
        output odd_sel,
        output in_valid,
        input  in_ready,
        input  tx_out,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  data_in,
        input  odd_sel,
        input  in_valid,
        output in_ready,
        output tx_out,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: START(0), DATA_W data bits LSB first, a parity bit
// (even or odd, chosen per word), then STOP(1).  Every frame bit lasts
// CLKS_PER_BIT clocks.  All outputs come straight from flops; they are
// computed from the next state so that tx_out shows the START level on the
// very first cycle after a word is accepted.
module parity_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    parity_frame_tx_if.slave bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [IDX_W-1:0]  bit_idx, bit_idx_n;
    logic [DATA_W-1:0] word, word_n;
    logic              parity, parity_n;

    logic              tx_q, tx_n;
    logic              busy_q, busy_n;
    logic              ready_q, ready_n;
    logic              done_q, done_n;

    logic              accept;
    logic              bit_end;

    // A word is taken only when we are advertising ready; the bit period ends on the last count.
    assign accept  = bus.in_valid && ready_q;
    assign bit_end = (bit_cnt == CNT_LAST);

    assign bus.in_ready   = ready_q;
    assign bus.tx_out     = tx_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

    // Next-state logic: walk START -> DATA -> PARITY -> STOP, advancing on each bit-period boundary.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        bit_idx_n = bit_idx;
        word_n    = word;
        parity_n  = parity;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = START;
                    bit_cnt_n = '0;
                    bit_idx_n = '0;
                    word_n    = bus.data_in;
                    parity_n  = (^bus.data_in) ^ bus.odd_sel;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    bit_idx_n = '0;
                end else begin
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_n = '0;
                    if (bit_idx == IDX_LAST) begin
                        state_n = PARITY;
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end else begin
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n   = STOP;
                    bit_cnt_n = '0;
                end else begin
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n   = IDLE;
                    bit_cnt_n = '0;
                    bit_idx_n = '0;
                    word_n    = '0;
                    parity_n  = 1'b0;
                    done_n    = 1'b1;
                end else begin
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n   = IDLE;
                bit_cnt_n = '0;
                bit_idx_n = '0;
                word_n    = '0;
                parity_n  = 1'b0;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered line level lines up with that state.
    always_comb begin
        tx_n    = 1'b1;
        busy_n  = (state_n != IDLE);
        ready_n = (state_n == IDLE);

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = word_n[bit_idx_n];
            PARITY:  tx_n = parity_n;
            default: tx_n = 1'b1;
        endcase
    end

    // State, counters, latched word and registered outputs; reset aborts any frame and holds the line idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            word    <= '0;
            parity  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            bit_idx <= bit_idx_n;
            word    <= word_n;
            parity  <= parity_n;
            tx_q    <= tx_n;
            busy_q  <= busy_n;
            ready_q <= ready_n;
            done_q  <= done_n;
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: two instances (4 and 1 clocks per bit) driven
// through their interfaces, line and status outputs compared each cycle
// against a frame model built from the framing rules.
module tb_parity_frame_tx;
    localparam int DATA_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int errors = 0;
    int checks = 0;

    parity_frame_tx_if #(.DATA_W(DATA_W)) bus0 ();
    parity_frame_tx_if #(.DATA_W(DATA_W)) bus1 ();

    parity_frame_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    parity_frame_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Safety net so a stuck run still ends with a report.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Frame model: position 0 is START, then data LSB first, parity, STOP.
    function automatic logic model_bit(logic [7:0] w, logic odd, int pos);
        if (pos == 0)
            return 1'b0;
        if (pos <= DATA_W)
            return w[pos-1];
        if (pos == DATA_W + 1)
            return (($countones(w) % 2) == 1) ^ odd;
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic o);
        if (sel == 0) begin
            bus0.in_valid = v;
            bus0.data_in  = d;
            bus0.odd_sel  = o;
        end else begin
            bus1.in_valid = v;
            bus1.data_in  = d;
            bus1.odd_sel  = o;
        end
    endtask

    // Returns {tx_out, busy, in_ready, frame_done} of the selected instance.
    function automatic logic [3:0] sample(input int sel);
        if (sel == 0)
            return {bus0.tx_out, bus0.busy, bus0.in_ready, bus0.frame_done};
        return {bus1.tx_out, bus1.busy, bus1.in_ready, bus1.frame_done};
    endfunction

    // Sends nframes words back to back; between accepts the inputs are scrambled.
    // Must be called at a negedge while the instance is idle.
    task automatic applyStimulus(input int sel, input int nframes,
                                 input logic [7:0] words [4], input logic odds [4],
                                 input bit hold_valid);
        int cpb;
        int flen;
        int period;
        logic [3:0] s;
        cpb    = (sel == 0) ? 4 : 1;
        flen   = (DATA_W + 3) * cpb;
        period = flen + 1;
        s = sample(sel);
        checkOutput("ready_before_accept", 32'(s[1]), 32'd1);
        for (int c = 0; c < nframes * period; c++) begin
            int pos;
            int f;
            pos = c % period;
            f   = c / period;
            if (pos == 0)
                drive(sel, 1'b1, words[f], odds[f]);
            else
                drive(sel, hold_valid ? 1'b1 : 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom));
            @(posedge clk);
            @(negedge clk);
            s = sample(sel);
            if (pos < flen) begin
                checkOutput($sformatf("tx s%0d f%0d p%0d", sel, f, pos), 32'(s[3]),
                            32'(model_bit(words[f], odds[f], pos / cpb)));
                checkOutput($sformatf("busy s%0d f%0d p%0d", sel, f, pos), 32'(s[2]), 32'd1);
                checkOutput($sformatf("ready s%0d f%0d p%0d", sel, f, pos), 32'(s[1]), 32'd0);
                checkOutput($sformatf("done s%0d f%0d p%0d", sel, f, pos), 32'(s[0]), 32'd0);
            end else begin
                checkOutput($sformatf("end_tx s%0d f%0d", sel, f), 32'(s[3]), 32'd1);
                checkOutput($sformatf("end_busy s%0d f%0d", sel, f), 32'(s[2]), 32'd0);
                checkOutput($sformatf("end_ready s%0d f%0d", sel, f), 32'(s[1]), 32'd1);
                checkOutput($sformatf("end_done s%0d f%0d", sel, f), 32'(s[0]), 32'd1);
            end
        end
        drive(sel, 1'b0, 8'h00, 1'b0);
    endtask

    // Directed sequence: reset, idle, fixed words, random streams, mid-frame reset, fast instance.
    initial begin
        logic [7:0] w [4];
        logic       o [4];
        logic [3:0] s;
        logic [7:0] aborted;
        int         seen;

        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        s = sample(0);
        checkOutput("rst_tx", 32'(s[3]), 32'd1);
        checkOutput("rst_busy", 32'(s[2]), 32'd0);
        checkOutput("rst_ready", 32'(s[1]), 32'd0);
        checkOutput("rst_done", 32'(s[0]), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        s = sample(0);
        checkOutput("post_rst_ready", 32'(s[1]), 32'd1);
        checkOutput("post_rst_tx", 32'(s[3]), 32'd1);

        // Idle with no request keeps the line high and the block free.
        repeat (3) begin
            @(negedge clk);
            s = sample(0);
            checkOutput("idle_tx", 32'(s[3]), 32'd1);
            checkOutput("idle_busy", 32'(s[2]), 32'd0);
        end

        $display("[TB] frame 0xA5 even");
        w = '{8'hA5, 8'h00, 8'h00, 8'h00};
        o = '{1'b0, 1'b0, 1'b0, 1'b0};
        applyStimulus(0, 1, w, o, 1'b0);
        @(negedge clk);
        s = sample(0);
        checkOutput("done_single_pulse", 32'(s[0]), 32'd0);

        $display("[TB] parity corner words, back to back");
        w = '{8'h07, 8'h07, 8'h00, 8'hFF};
        o = '{1'b1, 1'b0, 1'b0, 1'b1};
        applyStimulus(0, 4, w, o, 1'b1);
        w = '{8'hFF, 8'($urandom), 8'($urandom), 8'($urandom)};
        o = '{1'b0, 1'($urandom), 1'($urandom), 1'($urandom)};
        applyStimulus(0, 4, w, o, 1'b1);

        $display("[TB] random words, valid toggling while busy");
        w = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        o = '{1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)};
        applyStimulus(0, 4, w, o, 1'b0);

        $display("[TB] reset during data bit 3");
        @(negedge clk);
        aborted = 8'($urandom);
        drive(0, 1'b1, aborted, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 1'b0);
        repeat (17) @(negedge clk);
        s = sample(0);
        checkOutput("abort_bit3_level", 32'(s[3]), 32'(aborted[3]));
        rst_n = 1'b0;
        @(negedge clk);
        s = sample(0);
        checkOutput("abort_tx", 32'(s[3]), 32'd1);
        checkOutput("abort_busy", 32'(s[2]), 32'd0);
        checkOutput("abort_ready", 32'(s[1]), 32'd0);
        checkOutput("abort_done", 32'(s[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        s = sample(0);
        checkOutput("abort_release_ready", 32'(s[1]), 32'd1);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus0.frame_done === 1'b1)
                seen++;
        end
        checkOutput("abort_no_done", 32'(seen), 32'd0);

        w = '{8'h3C, 8'h00, 8'h00, 8'h00};
        o = '{1'b0, 1'b0, 1'b0, 1'b0};
        applyStimulus(0, 1, w, o, 1'b0);

        $display("[TB] one clock per bit");
        w = '{8'h81, 8'h00, 8'h00, 8'h00};
        o = '{1'b0, 1'b0, 1'b0, 1'b0};
        applyStimulus(1, 1, w, o, 1'b0);
        w = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        o = '{1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)};
        applyStimulus(1, 4, w, o, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parity_frame_tx.md
PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits; legal range 1..16.
REQ-002 Parameter CLKS_PER_BIT, default 4: clock cycles each serial bit is held; legal range 1..1024.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1: reset, synchronous and active-low; sampled only on clk rising edge.
REQ-005 Port data_in  input  DATA_W: payload word to frame.
REQ-006 Port odd_sel  input  1: parity mode; 0 = even parity, 1 = odd parity.
REQ-007 Port in_valid  input  1: upstream offers data_in/odd_sel.
REQ-008 Port in_ready  output  1: block can accept a word this cycle.
REQ-009 Port tx_out  output  1: serial line; idle level 1.
REQ-010 Port busy  output  1: high while a frame is being shifted out.
REQ-011 Port frame_done  output  1: single-cycle pulse after the stop bit completes.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-013 in_ready SHALL equal 1 exactly when state = IDLE and the block is not in reset.
REQ-014 Word acceptance SHALL occur on a rising edge where in_valid = 1 and in_ready = 1; data_in and odd_sel are latched at that edge, and the FSM moves to START.
REQ-015 Parity bit SHALL be computed from the latched word at acceptance: even mode = XOR of all DATA_W bits; odd mode = inverse of that XOR (total ones across data plus parity are even / odd respectively).
REQ-016 Frame order on tx_out: START = 0, then DATA_W data bits LSB first, then parity bit, then STOP = 1.
REQ-017 Each frame bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that reloads at every bit boundary.
REQ-018 A bit index counter SHALL step through data bits 0..DATA_W-1; DATA moves to PARITY after bit DATA_W-1 completes its full period.
REQ-019 tx_out SHALL drive the START level on the first cycle after acceptance; total frame time (START through STOP) is (DATA_W+3)*CLKS_PER_BIT cycles.
REQ-020 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-021 After the last STOP cycle the FSM SHALL return to IDLE and raise frame_done for exactly that first IDLE cycle; in_ready is 1 in the same cycle.
REQ-022 Back-to-back frames: a word accepted in the frame_done cycle SHALL start its START bit on the next cycle, giving exactly one idle-high cycle between frames.
REQ-023 Changes on data_in, odd_sel or in_valid while busy = 1 SHALL have no effect on the frame in progress.
REQ-024 in_valid = 0 in IDLE SHALL hold tx_out = 1, busy = 0, with no state change.

Reset
REQ-025 While rst_n = 0 at a rising edge: state -> IDLE, tx_out = 1, busy = 0, in_ready = 0, frame_done = 0, and all counters and latched data cleared.
REQ-026 Reset asserted mid-frame SHALL abort the frame: tx_out = 1 from the next edge, no frame_done pulse, and the partial word is discarded.
REQ-027 in_ready SHALL be 1 on the first cycle after rst_n returns high.

Verification (DATA_W=8, CLKS_PER_BIT=4 unless stated)
REQ-028 Accept 0xA5, odd_sel=0 -> tx_out 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, each held 4 cycles; busy high 44 cycles; one frame_done pulse.
REQ-029 Accept 0x07, odd_sel=1 -> parity bit 0; repeat with odd_sel=0 -> parity bit 1.
REQ-030 Accept 0x00 even -> parity 0; accept 0xFF odd -> parity 1; accept 0xFF even -> parity 0.
REQ-031 Hold in_valid=1 with new data_in every cycle -> exactly one accept per frame; accepts occur only in frame_done/IDLE cycles; each frame carries the word present at its accept edge; exactly one idle cycle between frames.
REQ-032 Pull rst_n low for 1 cycle during data bit 3 -> tx_out 1 next cycle, no frame_done, in_ready 1 after release; the next accepted 0x3C frames correctly.
REQ-033 CLKS_PER_BIT=1, accept 0x81 even -> 11-cycle frame 0,1,0,0,0,0,0,0,1,0,1.
